// File: rtl/id_alu_issue.sv
// RV64I decode for the ALU: one instruction per transfer into a single valid/ready register toward EX.
// Latency 1; in_ready = ~out_valid | out_ready, so a held entry stalls IF; flush drops held and incoming.
module id_alu_issue #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]   alu_src1,
  output logic [XLEN-1:0]   alu_src2,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        rd,
  output logic              rd_wen,
  output logic              sext32,
  output logic              is_load,
  output logic              is_store,
  output logic [2:0]        funct3,
  output logic              illegal,
  output logic              ebreak
);

  localparam logic [CTRL_W-1:0] OP_ADD  = 14'h2000;
  localparam logic [CTRL_W-1:0] OP_SUB  = 14'h1000;
  localparam logic [CTRL_W-1:0] OP_SLT  = 14'h0800;
  localparam logic [CTRL_W-1:0] OP_SLTU = 14'h0400;
  localparam logic [CTRL_W-1:0] OP_AND  = 14'h0200;
  localparam logic [CTRL_W-1:0] OP_OR   = 14'h0100;
  localparam logic [CTRL_W-1:0] OP_XOR  = 14'h0080;
  localparam logic [CTRL_W-1:0] OP_SLL  = 14'h0040;
  localparam logic [CTRL_W-1:0] OP_SRL  = 14'h0020;
  localparam logic [CTRL_W-1:0] OP_SRA  = 14'h0010;
  localparam logic [CTRL_W-1:0] OP_LUI  = 14'h0008;
  localparam logic [CTRL_W-1:0] OP_SRAW = 14'h0004;
  localparam logic [CTRL_W-1:0] OP_SLLW = 14'h0002;
  localparam logic [CTRL_W-1:0] OP_SRLW = 14'h0001;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32= 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt6, shamt5, four;

  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];

  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};
  assign four   = XLEN'(4);

  logic [CTRL_W-1:0] d_ctrl;
  logic [XLEN-1:0]   d_src1, d_src2, d_imm;
  logic              d_wr, d_sext, d_ld, d_st, d_ill, d_ebreak;

  always_comb begin
    d_ctrl   = '0;
    d_src1   = '0;
    d_src2   = '0;
    d_imm    = '0;
    d_wr     = 1'b0;
    d_sext   = 1'b0;
    d_ld     = 1'b0;
    d_st     = 1'b0;
    d_ill    = 1'b0;
    d_ebreak = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_ctrl = OP_LUI; d_src2 = imm_u; d_imm = imm_u; d_wr = 1'b1;
      end
      OPC_AUIPC: begin
        d_ctrl = OP_ADD; d_src1 = pc; d_src2 = imm_u; d_imm = imm_u; d_wr = 1'b1;
      end
      OPC_JAL: begin
        d_ctrl = OP_ADD; d_src1 = pc; d_src2 = four; d_imm = imm_j; d_wr = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) d_ctrl = OP_ADD;
        d_src1 = pc; d_src2 = four; d_imm = imm_i; d_wr = 1'b1;
      end
      OPC_OPIMM: begin
        d_src1 = rs1_data; d_src2 = imm_i; d_imm = imm_i; d_wr = 1'b1;
        case (f3)
          3'b000: d_ctrl = OP_ADD;
          3'b010: d_ctrl = OP_SLT;
          3'b011: d_ctrl = OP_SLTU;
          3'b100: d_ctrl = OP_XOR;
          3'b110: d_ctrl = OP_OR;
          3'b111: d_ctrl = OP_AND;
          3'b001: begin
            d_src2 = shamt6;
            if (inst[31:26] == 6'b000000) d_ctrl = OP_SLL;
          end
          default: begin
            d_src2 = shamt6;
            if (inst[31:26] == 6'b000000)      d_ctrl = OP_SRL;
            else if (inst[31:26] == 6'b010000) d_ctrl = OP_SRA;
          end
        endcase
      end
      OPC_OP: begin
        d_src1 = rs1_data; d_src2 = rs2_data; d_wr = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d_ctrl = OP_ADD;
            3'b001:  d_ctrl = OP_SLL;
            3'b010:  d_ctrl = OP_SLT;
            3'b011:  d_ctrl = OP_SLTU;
            3'b100:  d_ctrl = OP_XOR;
            3'b101:  d_ctrl = OP_SRL;
            3'b110:  d_ctrl = OP_OR;
            default: d_ctrl = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      d_ctrl = OP_SUB;
          else if (f3 == 3'b101) d_ctrl = OP_SRA;
        end
      end
      OPC_OPIMM32: begin
        d_src1 = rs1_data; d_imm = imm_i; d_wr = 1'b1; d_sext = 1'b1;
        if (f3 == 3'b000) begin
          d_ctrl = OP_ADD; d_src2 = imm_i;
        end else begin
          d_src2 = shamt5;
          if (f3 == 3'b001 && f7 == 7'b0000000)      d_ctrl = OP_SLLW;
          else if (f3 == 3'b101 && f7 == 7'b0000000) d_ctrl = OP_SRLW;
          else if (f3 == 3'b101 && f7 == 7'b0100000) d_ctrl = OP_SRAW;
        end
      end
      OPC_OP32: begin
        d_src1 = rs1_data; d_src2 = rs2_data; d_wr = 1'b1; d_sext = 1'b1;
        if (f7 == 7'b0000000) begin
          if (f3 == 3'b000)      d_ctrl = OP_ADD;
          else if (f3 == 3'b001) d_ctrl = OP_SLLW;
          else if (f3 == 3'b101) d_ctrl = OP_SRLW;
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      d_ctrl = OP_SUB;
          else if (f3 == 3'b101) d_ctrl = OP_SRAW;
        end
      end
      OPC_LOAD: begin
        if (f3 != 3'b111) d_ctrl = OP_ADD;
        d_src1 = rs1_data; d_src2 = imm_i; d_imm = imm_i; d_wr = 1'b1; d_ld = 1'b1;
      end
      OPC_STORE: begin
        if (f3[2] == 1'b0) d_ctrl = OP_ADD;
        d_src1 = rs1_data; d_src2 = imm_s; d_imm = imm_s; d_st = 1'b1;
      end
      OPC_BRANCH: begin
        d_src1 = rs1_data; d_src2 = rs2_data; d_imm = imm_b;
        case (f3)
          3'b000, 3'b001: d_ctrl = OP_SUB;
          3'b100, 3'b101: d_ctrl = OP_SLT;
          3'b110, 3'b111: d_ctrl = OP_SLTU;
          default:        d_ctrl = '0;
        endcase
      end
      default: begin
        if (inst == INST_EBREAK) d_ebreak = 1'b1;
      end
    endcase
    // Every legal op selected exactly one control bit; no selection means the encoding is not ours.
    if (d_ctrl == '0 && !d_ebreak) begin
      d_ill  = 1'b1;
      d_wr   = 1'b0;
      d_ld   = 1'b0;
      d_st   = 1'b0;
      d_sext = 1'b0;
      d_src1 = '0;
      d_src2 = '0;
      d_imm  = '0;
    end
    if (inst[11:7] == 5'd0) d_wr = 1'b0;
  end

  logic capture;
  assign in_ready = ~out_valid | out_ready;
  assign capture  = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_control <= '0;
      alu_src1    <= '0;
      alu_src2    <= '0;
      imm         <= '0;
      out_pc      <= '0;
      rd          <= '0;
      rd_wen      <= 1'b0;
      sext32      <= 1'b0;
      is_load     <= 1'b0;
      is_store    <= 1'b0;
      funct3      <= '0;
      illegal     <= 1'b0;
      ebreak      <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      alu_control <= d_ctrl;
      alu_src1    <= d_src1;
      alu_src2    <= d_src2;
      imm         <= d_imm;
      out_pc      <= pc;
      rd          <= inst[11:7];
      rd_wen      <= d_wr;
      sext32      <= d_sext;
      is_load     <= d_ld;
      is_store    <= d_st;
      funct3      <= f3;
      illegal     <= d_ill;
      ebreak      <= d_ebreak;
    end else if (out_ready | flush) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_alu_issue.sv
// Bench for id_alu_issue: directed spec cases then random traffic against a mnemonic-level decode model.
module tb_id_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        flush, out_valid, out_ready;
  logic [13:0] alu_control;
  logic [63:0] alu_src1, alu_src2, imm, out_pc;
  logic [4:0]  rd;
  logic        rd_wen, sext32, is_load, is_store, illegal, ebreak;
  logic [2:0]  funct3;

  id_alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .imm(imm), .out_pc(out_pc), .rd(rd),
    .rd_wen(rd_wen), .sext32(sext32), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .illegal(illegal), .ebreak(ebreak)
  );

  always #5 clk = ~clk;

  localparam int B_ADD = 13, B_SUB = 12, B_SLT = 11, B_SLTU = 10, B_AND = 9, B_OR = 8, B_XOR = 7;
  localparam int B_SLL = 6, B_SRL = 5, B_SRA = 4, B_LUI = 3, B_SRAW = 2, B_SLLW = 1, B_SRLW = 0;

  typedef struct packed {
    logic [13:0] ctrl;
    logic [63:0] s1, s2, imm, pc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wen, sext, ld, st, ill, ebk, full;
  } exp_t;

  int   ncmp = 0;
  int   nerr = 0;
  exp_t m;
  logic m_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected decode derived from the ISA tables: each mnemonic maps to an ALU op bit and operands.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t e;
    longint sx, ii, is_, ib, iu, ij;
    int idx;
    logic wr, ld, st, w32;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int opimm_tab[8];
    int op_tab[8];
    opimm_tab = '{B_ADD, -1, B_SLT, B_SLTU, B_XOR, -1, B_OR, B_AND};
    op_tab    = '{B_ADD, B_SLL, B_SLT, B_SLTU, B_XOR, B_SRL, B_OR, B_AND};
    e = '0;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    sx  = longint'($signed(i));
    ii  = sx >>> 20;
    is_ = ((sx >>> 25) <<< 5) | longint'(i[11:7]);
    ib  = ((sx >>> 31) <<< 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
    iu  = (sx >>> 12) <<< 12;
    ij  = ((sx >>> 31) <<< 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
    idx = -1; wr = 1'b1; ld = 1'b0; st = 1'b0; w32 = 1'b0;
    e.pc = p; e.rd = i[11:7]; e.f3 = f3;
    if (i == 32'h0010_0073) e.ebk = 1'b1;
    else if (opc == 7'h37) begin idx = B_LUI; e.s1 = 0; e.s2 = iu; e.imm = iu; end
    else if (opc == 7'h17) begin idx = B_ADD; e.s1 = p; e.s2 = iu; e.imm = iu; end
    else if (opc == 7'h6F) begin idx = B_ADD; e.s1 = p; e.s2 = 4; e.imm = ij; end
    else if (opc == 7'h67 && f3 == 0) begin idx = B_ADD; e.s1 = p; e.s2 = 4; e.imm = ii; end
    else if (opc == 7'h13) begin
      e.s1 = a; e.s2 = ii; e.imm = ii;
      if (f3 == 1 || f3 == 5) begin
        e.s2 = 64'(i[25:20]);
        if (i[31:26] == 6'h00)                idx = (f3 == 1) ? B_SLL : B_SRL;
        else if (i[31:26] == 6'h10 && f3 == 5) idx = B_SRA;
      end else idx = opimm_tab[f3];
    end
    else if (opc == 7'h33) begin
      e.s1 = a; e.s2 = b;
      if (f7 == 0) idx = op_tab[f3];
      else if (f7 == 7'h20 && f3 == 0) idx = B_SUB;
      else if (f7 == 7'h20 && f3 == 5) idx = B_SRA;
    end
    else if (opc == 7'h1B) begin
      w32 = 1'b1; e.s1 = a; e.imm = ii; e.s2 = 64'(i[24:20]);
      if (f3 == 0) begin idx = B_ADD; e.s2 = ii; end
      else if (f3 == 1 && f7 == 0) idx = B_SLLW;
      else if (f3 == 5 && f7 == 0) idx = B_SRLW;
      else if (f3 == 5 && f7 == 7'h20) idx = B_SRAW;
    end
    else if (opc == 7'h3B) begin
      w32 = 1'b1; e.s1 = a; e.s2 = b;
      if (f7 == 0 && f3 == 0) idx = B_ADD;
      else if (f7 == 0 && f3 == 1) idx = B_SLLW;
      else if (f7 == 0 && f3 == 5) idx = B_SRLW;
      else if (f7 == 7'h20 && f3 == 0) idx = B_SUB;
      else if (f7 == 7'h20 && f3 == 5) idx = B_SRAW;
    end
    else if (opc == 7'h03 && f3 != 7) begin idx = B_ADD; ld = 1'b1; e.s1 = a; e.s2 = ii; e.imm = ii; end
    else if (opc == 7'h23 && f3 < 4) begin idx = B_ADD; st = 1'b1; wr = 1'b0; e.s1 = a; e.s2 = is_; e.imm = is_; end
    else if (opc == 7'h63 && f3 != 2 && f3 != 3) begin
      idx = (f3 < 2) ? B_SUB : (f3 < 6) ? B_SLT : B_SLTU;
      wr = 1'b0; e.s1 = a; e.s2 = b; e.imm = ib;
    end
    if (e.ebk) e.full = 1'b0;
    else if (idx < 0) e.ill = 1'b1;
    else begin
      e.ctrl = 14'(1) << idx;
      e.full = 1'b1;
      e.wen  = wr && (i[11:7] != 0);
      e.ld   = ld; e.st = st; e.sext = w32;
    end
    return e;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("alu_control", alu_control, m.ctrl);
    check("illegal", illegal, m.ill);
    check("ebreak", ebreak, m.ebk);
    check("rd_wen", rd_wen, m.wen);
    check("is_load", is_load, m.ld);
    check("is_store", is_store, m.st);
    check("funct3", funct3, m.f3);
    check("rd", rd, m.rd);
    check("out_pc", out_pc, m.pc);
    if (m.full) begin
      check("alu_src1", alu_src1, m.s1);
      check("alu_src2", alu_src2, m.s2);
      check("imm", imm, m.imm);
      check("sext32", sext32, m.sext);
    end
  endtask

  // One clock: drive at the falling edge, check handshake, advance model at the rising edge, check outputs.
  task automatic step(input logic v, input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                      input logic [63:0] r2, input logic rdy, input logic fl);
    in_valid = v; inst = i; pc = p; rs1_data = r1; rs2_data = r2; out_ready = rdy; flush = fl;
    #1;
    check("in_ready", in_ready, !m_valid || rdy);
    check("rs1_addr", rs1_addr, i[19:15]);
    check("rs2_addr", rs2_addr, i[24:20]);
    @(posedge clk);
    if (v && (!m_valid || rdy) && !fl) begin
      m = model(i, p, r1, r2);
      m_valid = 1'b1;
    end else if (rdy || fl) m_valid = 1'b0;
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[12];
    logic [31:0] r;
    int sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h03, 7'h23, 7'h63, 7'h73};
    r = $urandom;
    sel = $urandom_range(0, 15);
    if (sel < 12) begin
      r[6:0] = ops[sel];
      if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (sel == 11 && $urandom_range(0, 1) == 1) r = 32'h0010_0073;
    end
    return r;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    m = '0; m.full = 1'b1; m_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    step(1'b1, 32'h0050_0093, 64'h1000, 64'h0, 64'h0, 1'b1, 1'b0);
    check("addi_valid", out_valid, 1'b1);
    check("addi_ctrl", alu_control, 14'h2000);
    check("addi_src2", alu_src2, 64'd5);
    check("addi_rd", rd, 5'd1);
    check("addi_wen", rd_wen, 1'b1);

    step(1'b1, 32'h4030_D11B, 64'h1004, 64'hFFFF_FFFF_8000_0000, 64'h7, 1'b1, 1'b0);
    check("sraiw_ctrl", alu_control, 14'h0004);
    check("sraiw_src1", alu_src1, 64'hFFFF_FFFF_8000_0000);
    check("sraiw_src2", alu_src2, 64'd3);
    check("sraiw_sext", sext32, 1'b1);

    step(1'b1, 32'h8000_01B7, 64'h1008, 64'h0, 64'h0, 1'b1, 1'b0);
    check("lui_neg_src2", alu_src2, 64'hFFFF_FFFF_8000_0000);
    step(1'b1, 32'h1234_51B7, 64'h100C, 64'h0, 64'h0, 1'b1, 1'b0);
    check("lui_ctrl", alu_control, 14'h0008);
    check("lui_src2", alu_src2, 64'h0000_0000_1234_5000);

    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h0050_0293, 64'h1010, 64'h0, 64'h0, 1'b0, 1'b0);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_ctrl", alu_control, 14'h0008);
      check("stall_pc", out_pc, 64'h100C);
    end
    step(1'b1, 32'h0050_0293, 64'h1010, 64'h0, 64'h0, 1'b1, 1'b0);
    check("release_rd", rd, 5'd5);

    step(1'b1, 32'h0070_0313, 64'h1014, 64'h0, 64'h0, 1'b1, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_hold_pc", out_pc, 64'h1010);

    step(1'b1, 32'hFFFF_FFFF, 64'h1018, 64'h0, 64'h0, 1'b1, 1'b0);
    check("ill_flag", illegal, 1'b1);
    check("ill_ctrl", alu_control, 14'h0);
    step(1'b1, 32'h0010_0073, 64'h101C, 64'h0, 64'h0, 1'b1, 1'b0);
    check("ebreak_flag", ebreak, 1'b1);
    check("ebreak_ill", illegal, 1'b0);

    step(1'b1, 32'h0050_0093, 64'h1020, 64'h0, 64'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ctrl", alu_control, 14'h0);
    check("arst_src2", alu_src2, 64'h0);
    check("arst_rd", rd, 5'd0);
    m = '0; m.full = 1'b1; m_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs();

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
